// File: rtl/div_seq.sv
// Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU group.
// Optional DIV_SEQ_EARLY_OUT_EN: divide-by-zero, signed overflow and unsigned /1 skip the iteration phase.
module div_seq #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int N     = WIDTH / UNROLL;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t state, nxt;

    logic [WIDTH-1:0] a_orig, dvd, dsr, rem, q_r;
    logic [CNT_W-1:0] cnt;
    logic is_signed, sel_rem, neg_q, neg_r, dbz, ovf;
    logic dbz_now, ovf_now, early;

    logic [WIDTH-1:0] rem_nx, dvd_nx, quo_fix, rmd_fix, fix_val;
    logic [WIDTH:0]   shifted, trial;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        mag = x[WIDTH-1] ? WIDTH'(-x) : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
        cond_neg = en ? (~x + 1'b1) : x;
    endfunction

    assign dbz_now = (dsr == '0);
    assign ovf_now = is_signed && (a_orig == MIN_NEG) && (dsr == '1);

`ifdef DIV_SEQ_EARLY_OUT_EN
    logic one, one_now;
    assign one_now = !is_signed && (dsr == WIDTH'(1));
    assign early   = dbz_now | ovf_now | one_now;
`else
    assign early   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (kill && state != IDLE) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && !kill) nxt = PREP;
                PREP:    nxt = early ? FIX : ITER;
                ITER:    if (cnt == '0) nxt = FIX;
                FIX:     nxt = DONE;
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // UNROLL restoring steps: a W+1-bit trial subtraction decides each quotient bit
    always_comb begin
        rem_nx  = rem;
        dvd_nx  = dvd;
        shifted = '0;
        trial   = '0;
        for (int i = 0; i < UNROLL; i++) begin
            shifted = {rem_nx, dvd_nx[WIDTH-1]};
            trial   = shifted - {1'b0, dsr};
            rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            dvd_nx  = {dvd_nx[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

    always_comb begin
        quo_fix = cond_neg(dvd, neg_q);
        rmd_fix = cond_neg(rem, neg_r);
        if (dbz) begin
            quo_fix = '1;
            rmd_fix = a_orig;
        end
        if (ovf) begin
            quo_fix = MIN_NEG;
            rmd_fix = '0;
        end
`ifdef DIV_SEQ_EARLY_OUT_EN
        if (one) begin
            quo_fix = a_orig;
            rmd_fix = '0;
        end
`endif
        fix_val = sel_rem ? rmd_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_orig    <= '0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            q_r       <= '0;
            cnt       <= '0;
            is_signed <= 1'b0;
            sel_rem   <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
`ifdef DIV_SEQ_EARLY_OUT_EN
            one       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        a_orig    <= a;
                        dsr       <= b;
                        // funct3 codes 0xx fall back to DIVU
                        is_signed <= mode[2] & ~mode[0];
                        sel_rem   <= mode[2] & mode[1];
                    end
                end
                PREP: begin
                    dvd   <= is_signed ? mag(a_orig) : a_orig;
                    dsr   <= is_signed ? mag(dsr) : dsr;
                    neg_q <= is_signed & (a_orig[WIDTH-1] ^ dsr[WIDTH-1]);
                    neg_r <= is_signed & a_orig[WIDTH-1];
                    dbz   <= dbz_now;
                    ovf   <= ovf_now;
`ifdef DIV_SEQ_EARLY_OUT_EN
                    one   <= one_now;
`endif
                    rem   <= '0;
                    cnt   <= CNT_INIT;
                end
                ITER: begin
                    rem <= rem_nx;
                    dvd <= dvd_nx;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (!kill) q_r <= fix_val;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign q    = q_r;

endmodule
